// File: rtl/bcd_sub3_serial.sv
// Purpose: digit-serial 3-digit packed-BCD subtractor, d = a - b - bin, units digit first.
// Latency: 3 cycles from the accepting edge to the done pulse; one operation per 4 cycles at best.
// Backpressure: none; start is ignored while busy. Optional input check under macro BCD_SUB_CHECK_EN.
module bcd_sub3_serial (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic [11:0] a,
    input  logic [11:0] b,
    input  logic        bin,
    output logic [11:0] d,
    output logic        bout,
    output logic        busy,
    output logic        done,
    output logic        err
);

    typedef enum logic {IDLE, SUB} state_t;

    state_t      state;
    state_t      state_nxt;
    logic [1:0]  idx;
    logic [11:0] a_sh;
    logic [11:0] b_sh;
    logic        brw;
    logic        accept;
    logic        last;
    logic [4:0]  t;
    logic [3:0]  dig;

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next state: accept only from IDLE, leave SUB after the hundreds digit
    always_comb begin
        state_nxt = state;
        accept    = 1'b0;
        last      = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    accept    = 1'b1;
                    state_nxt = SUB;
                end
            end
            SUB: begin
                if (idx == 2'd2) begin
                    last      = 1'b1;
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // One digit of subtraction; a negative 5-bit result is corrected by +10 and borrows
    always_comb begin
        t   = {1'b0, a_sh[3:0]} - {1'b0, b_sh[3:0]} - {4'b0000, brw};
        dig = t[4] ? (t[3:0] + 4'd10) : t[3:0];
    end

    // Datapath: operands shift down one digit per cycle, result digits land in place
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_sh <= '0;
            b_sh <= '0;
            brw  <= 1'b0;
            idx  <= '0;
            d    <= '0;
            bout <= 1'b0;
            busy <= 1'b0;
            done <= 1'b0;
        end else if (accept) begin
            a_sh <= a;
            b_sh <= b;
            brw  <= bin;
            idx  <= '0;
            busy <= 1'b1;
            done <= 1'b0;
        end else if (state == SUB) begin
            d[{idx, 2'b00} +: 4] <= dig;
            a_sh <= a_sh >> 4;
            b_sh <= b_sh >> 4;
            brw  <= t[4];
            idx  <= idx + 2'd1;
            if (last) begin
                idx  <= '0;
                busy <= 1'b0;
                done <= 1'b1;
                bout <= t[4];
            end
        end else begin
            done <= 1'b0;
        end
    end

`ifdef BCD_SUB_CHECK_EN
    function automatic logic non_bcd(input logic [3:0] n);
        return n > 4'd9;
    endfunction

    // Flag any non-BCD input digit at accept; held until the next accept
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err <= 1'b0;
        end else if (accept) begin
            err <= non_bcd(a[3:0]) | non_bcd(a[7:4]) | non_bcd(a[11:8]) |
                   non_bcd(b[3:0]) | non_bcd(b[7:4]) | non_bcd(b[11:8]);
        end
    end
`else
    assign err = 1'b0;
`endif

endmodule

// File: tb/tb_bcd_sub3_serial.sv
// Purpose: scoreboard bench for bcd_sub3_serial against an integer-arithmetic decimal model.
// Latency: checks busy/done timing around the 3-cycle operation and done-cycle back-to-back accept.
// Backpressure: start while busy must be ignored; asynchronous reset must abort without done.
module tb_bcd_sub3_serial;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic [11:0] a;
    logic [11:0] b;
    logic        bin;
    logic [11:0] d;
    logic        bout;
    logic        busy;
    logic        done;
    logic        err;

    typedef struct {
        logic [11:0] d;
        logic        bout;
        logic        err;
        bit          chk_d;
    } exp_t;

    exp_t sb[$];
    int   n_checks = 0;
    int   n_pass   = 0;
    int   n_done   = 0;
    int   n_push   = 0;

    bcd_sub3_serial dut (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start),
        .a     (a),
        .b     (b),
        .bin   (bin),
        .d     (d),
        .bout  (bout),
        .busy  (busy),
        .done  (done),
        .err   (err)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    function automatic bit nib_bad(input logic [11:0] x);
        return (x[3:0] > 4'd9) || (x[7:4] > 4'd9) || (x[11:8] > 4'd9);
    endfunction

    function automatic int bcd2int(input logic [11:0] x);
        return int'(x[11:8]) * 100 + int'(x[7:4]) * 10 + int'(x[3:0]);
    endfunction

    // Reference: decimal difference, wrapped into 0..999 with a borrow when negative
    function automatic exp_t model(input logic [11:0] av, input logic [11:0] bv, input logic bi);
        exp_t e;
        int   diff;
        diff   = bcd2int(av) - bcd2int(bv) - int'(bi);
        e.bout = (diff < 0);
        if (diff < 0) diff += 1000;
        e.d     = {4'(diff / 100), 4'((diff / 10) % 10), 4'(diff % 10)};
        e.chk_d = !(nib_bad(av) || nib_bad(bv));
`ifdef BCD_SUB_CHECK_EN
        e.err = nib_bad(av) || nib_bad(bv);
`else
        e.err = 1'b0;
`endif
        return e;
    endfunction

    function automatic logic [11:0] rnd_bcd();
        return {4'($urandom_range(9)), 4'($urandom_range(9)), 4'($urandom_range(9))};
    endfunction

    // Monitor: every done pulse must match the oldest outstanding expectation
    always @(negedge clk) begin
        if (rst_n === 1'b1 && done === 1'b1) begin
            n_done++;
            if (sb.size() == 0) begin
                check("unexpected_done", done, 1'b0);
            end else begin
                exp_t e;
                e = sb.pop_front();
                if (e.chk_d) check("d", d, e.d);
                check("bout", bout, e.bout);
                check("err", err, e.err);
            end
        end
    end

    task automatic wait_idle();
        int k = 0;
        while (busy === 1'b1 && k < 20) begin
            @(negedge clk);
            k++;
        end
        if (busy !== 1'b0) check("idle_timeout", busy, 1'b0);
    endtask

    // Present one start for one cycle; returns at the negedge after the accepting edge
    task automatic issue(input logic [11:0] av, input logic [11:0] bv, input logic bi, input bit push);
        wait_idle();
        a     = av;
        b     = bv;
        bin   = bi;
        start = 1'b1;
        if (push) begin
            sb.push_back(model(av, bv, bi));
            n_push++;
        end
        @(negedge clk);
        start = 1'b0;
        a     = 12'($urandom);
        b     = 12'($urandom);
        bin   = 1'($urandom);
    endtask

    // Operation with cycle-exact checks; returns in the done cycle
    task automatic timing_op(input logic [11:0] av, input logic [11:0] bv, input logic bi);
        issue(av, bv, bi, 1'b1);
        check("busy_n0", busy, 1'b1);
        check("done_n0", done, 1'b0);
        @(negedge clk);
        check("busy_n1", busy, 1'b1);
        @(negedge clk);
        check("busy_n2", busy, 1'b1);
        check("done_n2", done, 1'b0);
        @(negedge clk);
        check("busy_n3", busy, 1'b0);
        check("done_n3", done, 1'b1);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        // Asynchronous reset, checked before the first clock edge
        rst_n = 1'b0;
        start = 1'($urandom);
        a     = 12'($urandom);
        b     = 12'($urandom);
        bin   = 1'($urandom);
        #3;
        check("rst_d", d, 12'h000);
        check("rst_bout", bout, 1'b0);
        check("rst_busy", busy, 1'b0);
        check("rst_done", done, 1'b0);
        check("rst_err", err, 1'b0);
        @(negedge clk);
        start = 1'b0;
        rst_n = 1'b1;
        @(negedge clk);

        // Simple difference with timing, then a start in the done cycle
        timing_op(12'h225, 12'h100, 1'b0);
        timing_op(12'h050, 12'h007, 1'b0);
        @(negedge clk);
        check("done_n4", done, 1'b0);

        // Negative result and all-nines / borrow-in corners
        issue(12'h100, 12'h225, 1'b0, 1'b1);
        issue(12'h999, 12'h999, 1'b1, 1'b1);
        issue(12'h999, 12'h999, 1'b0, 1'b1);
        issue(12'h000, 12'h000, 1'b1, 1'b1);

        // Starts during a running operation are ignored
        issue(12'h432, 12'h198, 1'b1, 1'b1);
        start = 1'b1;
        a     = 12'h111;
        b     = 12'h999;
        @(negedge clk);
        a     = 12'h777;
        @(negedge clk);
        start = 1'b0;

        // Abort mid-operation: outputs clear at once and no done follows
        issue(12'h987, 12'h123, 1'b0, 1'b0);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("abort_busy", busy, 1'b0);
        check("abort_d", d, 12'h000);
        check("abort_bout", bout, 1'b0);
        check("abort_done", done, 1'b0);
        check("abort_err", err, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("abort_no_done", done, 1'b0);
        end

        // Non-BCD input flags err (when built), then a valid op clears it
        issue(12'h1A0, 12'h010, 1'b0, 1'b1);
        issue(12'h321, 12'h123, 1'b0, 1'b1);

        // Randomised operations with random idle gaps
        for (int i = 0; i < 40; i++) begin
            int gap;
            issue(rnd_bcd(), rnd_bcd(), 1'($urandom), 1'b1);
            gap = $urandom_range(0, 5);
            for (int g = 0; g < gap; g++) @(negedge clk);
        end

        // Drain
        for (int k = 0; k < 50 && sb.size() != 0; k++) @(negedge clk);
        @(negedge clk);
        check("sb_drained", sb.size(), 0);
        check("done_count", n_done, n_push);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
